// File: rtl/qspi_flash_ctrl.sv
// qspi_flash_ctrl: turns each core read into a CMD/ADDR/DUMMY/DATA byte-op sequence for a qspi byte engine
package qspi_flash_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;
  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;
endpackage

module qspi_flash_ctrl
  import qspi_flash_pkg::*;
#(
  parameter logic [7:0] CMD = 8'hEB,
  parameter int DUMMY_BYTES = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  mem_in,
  output mem_out_type mem_out,
  output logic        err,
  output mem_in_type  q_in,
  input  mem_out_type q_out
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, COMMAND, ADDR, DUMMY, DATA, DONE} state_t;
  state_t state, ns;
  logic wait_ph, nwait, abort, nabort, issue, wr, accept, wr_ack;
  logic [2:0] idx, nidx;
  logic [23:0] addr, naddr;
  logic [31:0] word, nword;
  logic [TW-1:0] cnt, ncnt;
  logic [7:0] obyte;
  assign accept = state == IDLE && mem_in.mem_valid && !mem_out.mem_ready;
  assign wr_ack = accept && mem_in.mem_wstrb != 4'h0;
  always_comb begin
    ns = state;
    nwait = wait_ph;
    nidx = idx;
    naddr = addr;
    nword = word;
    ncnt = cnt;
    nabort = abort;
    case (state)
      IDLE: if (accept && mem_in.mem_wstrb == 4'h0) begin
        ns = COMMAND;
        nwait = 1'b0;
        nidx = 3'd0;
        naddr = mem_in.mem_addr[23:0];
        nabort = 1'b0;
      end
      DONE: ns = IDLE;
      default: if (!wait_ph) begin
        nwait = 1'b1;
        ncnt = '0;
      end else if (q_out.mem_ready) begin
        nwait = 1'b0;
        nidx = idx + 3'd1;
        if (state == DATA) nword[{idx[1:0], 3'b000} +: 8] = q_out.mem_rdata[7:0];
        if (state == COMMAND) begin
          ns = ADDR;
          nidx = 3'd0;
        end else if (state == ADDR && idx == 3'd2) begin
          ns = DUMMY_BYTES == 0 ? DATA : DUMMY;
          nidx = 3'd0;
        end else if (state == DUMMY && idx == 3'(DUMMY_BYTES - 1)) begin
          ns = DATA;
          nidx = 3'd0;
        end else if (state == DATA && idx == 3'd3) ns = DONE;
      end else if (cnt == TW'(TIMEOUT - 1)) begin
        ns = DONE;
        nabort = 1'b1;
      end else ncnt = cnt + 1'b1;
    endcase
  end
  // outputs are registered from next-state so ISSUE is visible in the cycle the op starts
  assign issue = ns != IDLE && ns != DONE && !nwait;
  assign wr = ns == COMMAND || ns == ADDR;
  assign obyte = ns == COMMAND ? CMD : nidx == 3'd0 ? naddr[23:16] : nidx == 3'd1 ? naddr[15:8] : naddr[7:0];
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wait_ph <= 1'b0;
      idx <= 3'd0;
      addr <= '0;
      word <= '0;
      cnt <= '0;
      abort <= 1'b0;
      mem_out <= '0;
      err <= 1'b0;
      q_in <= '0;
    end else begin
      state <= ns;
      wait_ph <= nwait;
      idx <= nidx;
      addr <= naddr;
      word <= nword;
      cnt <= ncnt;
      abort <= nabort;
      q_in.mem_valid <= issue;
      q_in.mem_addr <= '0;
      q_in.mem_wstrb <= issue && wr ? 4'hF : 4'h0;
      q_in.mem_wdata <= issue && wr ? {24'h0, obyte} : 32'h0;
      mem_out.mem_ready <= ns == DONE || wr_ack;
      if (ns == DONE) mem_out.mem_rdata <= nabort ? 32'h0 : nword;
      err <= ns == DONE && nabort;
    end
  end
endmodule
